hero_write_rx: RTL
==================

Name: hero_write_rx

Overview:
- Receiving end of the hero write bus: accepts hero_write_t beats (cycle_type, wdat, clk_en) from a hero write transmitter.
- Frames beats into transactions: VALID beats continue a transaction, a DONE beat ends it. Buffers beats in a credit-managed FIFO and presents them downstream as a valid/ready beat stream with a last marker.
- Returns one credit per freed FIFO entry so the transmitter never overruns the buffer.
- Detects and flags protocol errors: overflow, over-length transactions and illegal cycle types.

Parameters:
- HERO_WIDTH, 36, width of wdat / out_dat.
- DEPTH, 8, beat FIFO entries; power of 2, minimum 2; equals the transmitter's initial credit count.
- MAX_BEATS, 16, maximum beats per transaction including the DONE beat; minimum 2.

Ports:
- clk  in  1  single clock.
- rst_n  in  1  asynchronous assert, active-low reset.
- hw_cycle_type  in  2  0=IDLE, 1=VALID, 2=DONE, 3=illegal.
- hw_wdat  in  HERO_WIDTH  beat data.
- hw_clk_en  in  1  beat qualifier; a beat exists only when 1 and cycle_type != IDLE.
- crd_rtn  out  1  one-cycle pulse, returns one credit to the transmitter.
- out_vld  out  1  FIFO head valid.
- out_rdy  in  1  downstream accept.
- out_dat  out  HERO_WIDTH  head beat data.
- out_last  out  1  head beat ends its transaction.
- txn_cnt  out  16  completed transactions written to the FIFO; wraps at 2^16.
- err_ovf  out  1  sticky: beat arrived with FIFO full.
- err_len  out  1  sticky: transaction exceeded MAX_BEATS.
- err_illegal  out  1  sticky: cycle_type==3 seen with clk_en=1.
- err_clr  in  1  synchronous clear of all three sticky errors.

Behaviour:
- Reset: all outputs 0, FIFO empty, state IDLE, beat counter 0.
- Beat handling:
  - A beat is "taken" when hw_clk_en=1 and hw_cycle_type is VALID or DONE.
  - When hw_clk_en=0, cycle_type is ignored entirely.
  - Illegal type 3: set err_illegal. The beat is not written and framing state is unchanged.
- FSM states: IDLE (no open transaction), BODY (open transaction), DROP (discarding the tail of an over-length transaction).
  - IDLE + VALID: write the beat with last=0, beat_cnt=1, go to BODY.
  - IDLE + DONE: single-beat transaction; write with last=1, txn_cnt+1, stay in IDLE.
  - BODY + VALID:
    - If beat_cnt==MAX_BEATS-1: write with last=1, set err_len, txn_cnt+1, go to DROP.
    - Otherwise write with last=0 and increment beat_cnt.
  - BODY + DONE: write with last=1, txn_cnt+1, beat_cnt=0, go to IDLE.
  - DROP: VALID beats are discarded (not written, no credit consumed). DONE is discarded and the FSM returns to IDLE.
- FIFO:
  - Write lands at cycle N; out_vld is visible at N+1 (one-cycle latency).
  - Pop occurs when out_vld && out_rdy. out_dat and out_last hold stable while out_vld=1 and out_rdy=0.
  - Simultaneous push and pop when full is legal only if the pop frees the slot. It is handled as a pop plus push; occupancy is unchanged and no overflow is flagged.
  - Push when full with no pop: beat dropped, err_ovf set. Framing still advances as if the beat were written, so a later DONE still closes the transaction. txn_cnt still increments on DONE.
  - Pointers wrap modulo DEPTH; a separate count register, 0..DEPTH, distinguishes full from empty.
- Credits: crd_rtn=1 in cycle N+1 for each pop in cycle N, giving at most one pulse per cycle. Discarded beats (DROP, illegal) return no credit.
- Errors:
  - err_* set in the cycle after detection and hold until err_clr=1.
  - If err_clr=1 and a new error occur in the same cycle, set wins.
- Reset mid-transaction: FIFO contents, state and counters are lost. Any unreturned credits are not returned; the transmitter is reset together with this block.

Test Plan:
- Single transaction: VALID,VALID,DONE with wdat 0x1,0x2,0x3 and out_rdy=1 -> out beats 0x1/0x2/0x3 appear one cycle after each input, out_last only on 0x3, txn_cnt=1, three crd_rtn pulses.
- Backpressure/full: out_rdy=0, DEPTH=8, 9 VALID beats -> out_vld=1 holding beat 0, beat 9 dropped, err_ovf=1 next cycle, zero crd_rtn. Then out_rdy=1 -> 8 pops, 8 crd_rtn pulses.
- Over-length: MAX_BEATS=16, 20 VALID then DONE -> 16 beats written, 16th has last=1, err_len=1, 4 VALID + DONE discarded, FSM back in IDLE, txn_cnt=1.
- Single-beat and illegal: DONE (wdat 0xA), then type 3 (wdat 0xB), then DONE (wdat 0xC) -> outputs 0xA (last=1) and 0xC (last=1), err_illegal=1, txn_cnt=2. Then err_clr pulse -> err_illegal=0.
- clk_en gating: VALID with clk_en=0 for 5 cycles, then VALID,DONE with clk_en=1 -> exactly 2 beats output.
- Full with simultaneous pop/push: FIFO full, out_rdy=1 and a VALID beat in the same cycle -> count stays 8, no err_ovf, one crd_rtn. Then assert rst_n=0 mid-transaction -> all outputs 0 immediately.

Source files
------------

// File: rtl/hero_write_rx.sv
// hero_write_rx: frames hero write beats into transactions, buffers them in a
// credit-managed FIFO, returns credits on pop and flags protocol errors.
module hero_write_rx #(
  parameter int HERO_WIDTH = 36,
  parameter int DEPTH      = 8,
  parameter int MAX_BEATS  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [1:0]            hw_cycle_type,
  input  logic [HERO_WIDTH-1:0] hw_wdat,
  input  logic                  hw_clk_en,
  output logic                  crd_rtn,
  output logic                  out_vld,
  input  logic                  out_rdy,
  output logic [HERO_WIDTH-1:0] out_dat,
  output logic                  out_last,
  output logic [15:0]           txn_cnt,
  output logic                  err_ovf,
  output logic                  err_len,
  output logic                  err_illegal,
  input  logic                  err_clr
);
  localparam int AW = $clog2(DEPTH);
  localparam int BW = $clog2(MAX_BEATS);
  typedef enum logic [1:0] {IDLE, BODY, DROP} state_e;
  state_e                state_q, state_d;
  logic [BW-1:0]         beat_cnt_q, beat_cnt_d;
  logic [HERO_WIDTH:0]   mem_q [DEPTH];
  logic [AW-1:0]         wr_ptr_q, rd_ptr_q;
  logic [AW:0]           cnt_q, cnt_d;
  logic [15:0]           txn_cnt_q;
  logic                  crd_q, ovf_q, len_q, ill_q;
  logic                  is_vld, is_done, is_ill, len_hit;
  logic                  wr_req, wr_last, pop, full, push, ovf_set;
  assign is_vld  = hw_clk_en && hw_cycle_type == 2'd1;
  assign is_done = hw_clk_en && hw_cycle_type == 2'd2;
  assign is_ill  = hw_clk_en && hw_cycle_type == 2'd3;
  assign len_hit = state_q == BODY && is_vld && beat_cnt_q == BW'(MAX_BEATS - 1);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q    <= IDLE;
      beat_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      beat_cnt_q <= beat_cnt_d;
    end
  always_comb begin
    state_d    = state_q;
    beat_cnt_d = beat_cnt_q;
    if (is_vld || is_done)
      case (state_q)
        IDLE: begin
          state_d    = is_vld ? BODY : IDLE;
          beat_cnt_d = is_vld ? BW'(1) : '0;
        end
        BODY: begin
          state_d    = is_done ? IDLE : (len_hit ? DROP : BODY);
          beat_cnt_d = (is_done || len_hit) ? '0 : beat_cnt_q + 1'b1;
        end
        DROP: begin
          state_d    = is_done ? IDLE : DROP;
          beat_cnt_d = '0;
        end
        default: begin
          state_d    = IDLE;
          beat_cnt_d = '0;
        end
      endcase
  end
  always_comb begin
    wr_req  = (is_vld || is_done) && state_q != DROP;
    wr_last = is_done || len_hit;
  end
  // A full FIFO still accepts a push when the same-cycle pop frees the slot.
  assign pop     = out_vld && out_rdy;
  assign full    = cnt_q == (AW+1)'(DEPTH);
  assign push    = wr_req && (!full || pop);
  assign ovf_set = wr_req && full && !pop;
  assign cnt_d   = cnt_q + (AW+1)'(push) - (AW+1)'(pop);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      cnt_q     <= '0;
      txn_cnt_q <= '0;
      crd_q     <= 1'b0;
      ovf_q     <= 1'b0;
      len_q     <= 1'b0;
      ill_q     <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_q + AW'(push);
      rd_ptr_q  <= rd_ptr_q + AW'(pop);
      cnt_q     <= cnt_d;
      txn_cnt_q <= txn_cnt_q + 16'(wr_req && wr_last);
      crd_q     <= pop;
      ovf_q     <= ovf_set || (ovf_q && !err_clr);
      len_q     <= len_hit || (len_q && !err_clr);
      ill_q     <= is_ill || (ill_q && !err_clr);
    end
  always_ff @(posedge clk)
    if (push) mem_q[wr_ptr_q] <= {wr_last, hw_wdat};
  assign out_vld     = cnt_q != '0;
  assign out_dat     = out_vld ? mem_q[rd_ptr_q][HERO_WIDTH-1:0] : '0;
  assign out_last    = out_vld && mem_q[rd_ptr_q][HERO_WIDTH];
  assign crd_rtn     = crd_q;
  assign txn_cnt     = txn_cnt_q;
  assign err_ovf     = ovf_q;
  assign err_len     = len_q;
  assign err_illegal = ill_q;
endmodule
